// File: rtl/free_list.sv
// free_list -- circular FIFO of free physical register tags.
//
// Hands new PR tags to the rename stage (up to 3 per cycle, slot 2 oldest)
// and takes back Told tags at retire (up to 3 per cycle). On branch
// recovery every non-architectural PR becomes free again in one cycle.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   alloc_req[2:0]      per-slot request for a new PR
//   BPRecoverEN         recovery pulse; suppresses grants this cycle
//   Retire_EN[2:0]      per-slot retire enable, frees Told_in[i]
//   Told_in[2:0]        tags released at retire
//   free_pr[2:0]        tag offered to each slot (combinational)
//   alloc_gnt[2:0]      slot i took free_pr[i] this cycle
//   free_avail[1:0]     min(free_count, 3)
//   free_count          current occupancy, 0..DEPTH
//
// Optional build macro FREELIST_DEBUG_EN adds entries_disp, head_disp and
// tail_disp, which mirror the internal storage and pointers.
module free_list #(
  parameter  int PR_NUM = 64,
  parameter  int AR_NUM = 32,
  parameter  int PR_W   = 6,
  localparam int DEPTH  = PR_NUM - AR_NUM,
  localparam int HW     = $clog2(DEPTH),
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [2:0]           alloc_req,
  input  logic                 BPRecoverEN,
  input  logic [2:0]           Retire_EN,
  input  logic [2:0][PR_W-1:0] Told_in,
  output logic [2:0][PR_W-1:0] free_pr,
  output logic [2:0]           alloc_gnt,
  output logic [1:0]           free_avail,
  output logic [CW-1:0]        free_count
`ifdef FREELIST_DEBUG_EN
  ,
  output logic [DEPTH-1:0][PR_W-1:0] entries_disp,
  output logic [HW-1:0]              head_disp,
  output logic [HW-1:0]              tail_disp
`endif
);

  logic [DEPTH-1:0][PR_W-1:0] entries_q, entries_d;
  logic [HW-1:0]              head_q, head_d;
  logic [HW-1:0]              tail_q, tail_d;
  logic [CW-1:0]              count_q, count_d;
  logic [1:0]                 n_gnt, n_ret;
  logic [1:0]                 alloc_k, ret_j;

  // base + off modulo DEPTH; off never exceeds 3, so one subtract suffices.
  function automatic logic [HW-1:0] wrap(input logic [HW-1:0] base, input logic [1:0] off);
    logic [HW:0] sum;
    sum = {1'b0, base} + {{(HW-1){1'b0}}, off};
    if (sum >= (HW+1)'(DEPTH)) sum = sum - (HW+1)'(DEPTH);
    return sum[HW-1:0];
  endfunction

  // Allocation: requesters take consecutive entries from head, oldest slot
  // first. Grants form a prefix of the requesters, bounded by the current
  // count (same-cycle frees are not bypassed).
  always_comb begin
    alloc_k   = '0;
    n_gnt     = '0;
    alloc_gnt = '0;
    free_pr   = '0;
    for (int s = 2; s >= 0; s--) begin
      free_pr[s] = entries_q[wrap(head_q, alloc_k)];
      if (alloc_req[s]) begin
        if (!BPRecoverEN && (CW'(alloc_k) < count_q)) begin
          alloc_gnt[s] = 1'b1;
          n_gnt        = n_gnt + 2'd1;
        end
        alloc_k = alloc_k + 2'd1;
      end
    end
  end

  // Free: enabled retire slots are compacted onto consecutive tail entries.
  always_comb begin
    entries_d = entries_q;
    ret_j     = '0;
    for (int s = 2; s >= 0; s--) begin
      if (Retire_EN[s]) begin
        entries_d[wrap(tail_q, ret_j)] = Told_in[s];
        ret_j = ret_j + 2'd1;
      end
    end
    n_ret  = ret_j;
    tail_d = wrap(tail_q, n_ret);
    // Recovery: everything between the new tail and the old head is a
    // speculative tag, so the whole ring becomes free starting at tail.
    if (BPRecoverEN) begin
      head_d  = tail_d;
      count_d = CW'(DEPTH);
    end else begin
      head_d  = wrap(head_q, n_gnt);
      count_d = count_q - CW'(n_gnt) + CW'(n_ret);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= PR_W'(AR_NUM + i);
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= CW'(DEPTH);
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  assign free_count = count_q;
  assign free_avail = (count_q >= CW'(3)) ? 2'd3 : count_q[1:0];

`ifdef FREELIST_DEBUG_EN
  assign entries_disp = entries_q;
  assign head_disp    = head_q;
  assign tail_disp    = tail_q;
`endif

`ifndef SYNTHESIS
  // Overflow is a caller bug; the ring itself does not guard against it.
  always @(posedge clock) begin
    if (reset && !BPRecoverEN &&
        (({1'b0, count_q} - (CW+1)'(n_gnt) + (CW+1)'(n_ret)) > (CW+1)'(DEPTH)))
      $error("free_list overflow: count=%0d gnt=%0d ret=%0d", count_q, n_gnt, n_ret);
  end
`endif

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list. A queue model of the free list
// predicts grants and tags; expectations are pushed to a scoreboard when
// stimulus is driven and popped when the outputs are sampled.
module tb_free_list;
  localparam int PR_W  = 6;
  localparam int DEPTH = 32;

  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic [2:0]           alloc_req = '0;
  logic                 BPRecoverEN = 1'b0;
  logic [2:0]           Retire_EN = '0;
  logic [2:0][PR_W-1:0] Told_in = '0;
  logic [2:0][PR_W-1:0] free_pr;
  logic [2:0]           alloc_gnt;
  logic [1:0]           free_avail;
  logic [5:0]           free_count;
`ifdef FREELIST_DEBUG_EN
  logic [DEPTH-1:0][PR_W-1:0] entries_disp;
  logic [4:0]                 head_disp, tail_disp;
`endif

  free_list dut (
    .clock       (clock),
    .reset       (reset),
    .alloc_req   (alloc_req),
    .BPRecoverEN (BPRecoverEN),
    .Retire_EN   (Retire_EN),
    .Told_in     (Told_in),
    .free_pr     (free_pr),
    .alloc_gnt   (alloc_gnt),
    .free_avail  (free_avail),
    .free_count  (free_count)
`ifdef FREELIST_DEBUG_EN
    ,
    .entries_disp(entries_disp),
    .head_disp   (head_disp),
    .tail_disp   (tail_disp)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: fq = free tags in allocation order, infl = granted tags oldest
  // first (retire makes the oldest one architectural). After recovery the
  // order of fq is not predicted, only its contents.
  int fq[$];
  int infl[$];
  bit unordered;
  int alloc_total, ret_total;

  typedef struct {
    logic [2:0] gnt;
    int         pr[3];
    int         cnt;
    int         avail;
  } exp_t;
  exp_t sb[$];

  task automatic model_reset();
    fq.delete();
    infl.delete();
    for (int i = 0; i < DEPTH; i++) fq.push_back(32 + i);
    unordered   = 1'b0;
    alloc_total = 0;
    ret_total   = 0;
  endtask

  // Called at posedge+1: drive, check at posedge+2, advance one cycle.
  task automatic drive_cycle(input logic [2:0] req, input logic [2:0] ret,
                             input int t2, input int t1, input int t0, input logic bp);
    exp_t e;
    int   k, tag, idx;
    int   told[3];
    told[2] = t2; told[1] = t1; told[0] = t0;
    alloc_req   = req;
    Retire_EN   = ret;
    BPRecoverEN = bp;
    for (int s = 0; s < 3; s++) Told_in[s] = PR_W'(told[s]);

    e.gnt   = '0;
    e.pr    = '{0, 0, 0};
    e.cnt   = fq.size();
    e.avail = (fq.size() > 3) ? 3 : fq.size();
    k = 0;
    for (int s = 2; s >= 0; s--) begin
      if (req[s]) begin
        if (!bp && k < fq.size()) begin
          e.gnt[s] = 1'b1;
          if (!unordered) e.pr[s] = fq[k];
        end
        k++;
      end
    end
    sb.push_back(e);

    #1;
    e = sb.pop_front();
    n_checks++;
    if (alloc_gnt !== e.gnt) begin
      n_fail++;
      $display("FAIL alloc_gnt: got %b want %b (t=%0t)", alloc_gnt, e.gnt, $time);
    end
    n_checks++;
    if (free_count !== 6'(e.cnt)) begin
      n_fail++;
      $display("FAIL free_count: got %0d want %0d (t=%0t)", free_count, e.cnt, $time);
    end
    n_checks++;
    if (free_avail !== 2'(e.avail)) begin
      n_fail++;
      $display("FAIL free_avail: got %0d want %0d (t=%0t)", free_avail, e.avail, $time);
    end
    for (int s = 2; s >= 0; s--) begin
      if (e.gnt[s]) begin
        n_checks++;
        if (!unordered) begin
          tag = fq.pop_front();
          if (free_pr[s] !== PR_W'(tag)) begin
            n_fail++;
            $display("FAIL free_pr[%0d]: got %0d want %0d (t=%0t)", s, free_pr[s], tag, $time);
          end
        end else begin
          idx = -1;
          foreach (fq[i]) if (idx < 0 && fq[i] == int'(free_pr[s])) idx = i;
          if (idx < 0) begin
            n_fail++;
            $display("FAIL recovered_tag[%0d]: got %0d want a reclaimable unused tag (t=%0t)",
                     s, free_pr[s], $time);
            tag = fq.pop_front();
          end else begin
            tag = fq[idx];
            fq.delete(idx);
          end
        end
        infl.push_back(tag);
        alloc_total++;
      end
    end
    for (int s = 2; s >= 0; s--) begin
      if (ret[s]) begin
        fq.push_back(told[s]);
        if (infl.size() > 0) void'(infl.pop_front());
        ret_total++;
      end
    end
    if (bp) begin
      foreach (infl[i]) fq.push_back(infl[i]);
      infl.delete();
      unordered = 1'b1;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    alloc_req = '0; Retire_EN = '0; BPRecoverEN = 1'b0; Told_in = '0;
  endtask

  task automatic do_reset();
    idle();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    #12;
    n_checks++;
    if (free_count !== 6'd32) begin n_fail++; $display("FAIL reset_count: got %0d want 32", free_count); end
    n_checks++;
    if (free_avail !== 2'd3) begin n_fail++; $display("FAIL reset_avail: got %0d want 3", free_avail); end
    n_checks++;
    if (alloc_gnt !== 3'b000) begin n_fail++; $display("FAIL reset_gnt: got %b want 000", alloc_gnt); end
    n_checks++;
    if (free_pr[2] !== 6'd32) begin n_fail++; $display("FAIL reset_pr2: got %0d want 32", free_pr[2]); end
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    @(posedge clock);
    #1;
  endtask

  task automatic test_alloc_all();
    do_reset();
    drive_cycle(3'b111, 3'b000, 0, 0, 0, 1'b0);  // 32,33,34
    drive_cycle(3'b100, 3'b000, 0, 0, 0, 1'b0);  // count 29, slot2 gets 35
    idle();
  endtask

  task automatic test_alloc_sparse();
    do_reset();
    drive_cycle(3'b101, 3'b000, 0, 0, 0, 1'b0);  // slot2=32, slot0=33
    drive_cycle(3'b000, 3'b000, 0, 0, 0, 1'b0);  // count 30
    idle();
  endtask

  task automatic test_exhaust();
    do_reset();
    for (int c = 0; c < 11; c++) drive_cycle(3'b111, 3'b000, 0, 0, 0, 1'b0);
    drive_cycle(3'b111, 3'b000, 0, 0, 0, 1'b0);  // empty: no grants
    idle();
  endtask

  // Continues from the empty state left by test_exhaust.
  task automatic test_retire_from_empty();
    drive_cycle(3'b000, 3'b110, 5, 9, 0, 1'b0);
    drive_cycle(3'b111, 3'b000, 0, 0, 0, 1'b0);  // 5, 9 granted, slot0 not
    idle();
  endtask

  task automatic test_recovery();
    do_reset();
    drive_cycle(3'b111, 3'b000, 0, 0, 0, 1'b0);
    drive_cycle(3'b111, 3'b000, 0, 0, 0, 1'b0);
    drive_cycle(3'b111, 3'b000, 0, 0, 0, 1'b0);
    drive_cycle(3'b100, 3'b000, 0, 0, 0, 1'b0);
    drive_cycle(3'b000, 3'b111, 0, 1, 2, 1'b0);
    drive_cycle(3'b000, 3'b100, 3, 0, 0, 1'b0);
    drive_cycle(3'b111, 3'b100, 4, 0, 0, 1'b1);  // grants suppressed
    for (int c = 0; c < 11; c++) drive_cycle(3'b111, 3'b000, 0, 0, 0, 1'b0);
    drive_cycle(3'b111, 3'b000, 0, 0, 0, 1'b0);  // all 32 consumed
    idle();
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int c = 0; c < 8; c++) drive_cycle(3'b111, 3'b000, 0, 0, 0, 1'b0);
    drive_cycle(3'b100, 3'b000, 0, 0, 0, 1'b0);
    n_checks++;
    if (free_count !== 6'd7) begin n_fail++; $display("FAIL pre_reset_count: got %0d want 7", free_count); end
    alloc_req = 3'b111;
    #3;
    reset = 1'b0;  // mid-cycle, no clock edge nearby
    #1;
    n_checks++;
    if (free_count !== 6'd32) begin n_fail++; $display("FAIL async_count: got %0d want 32", free_count); end
    n_checks++;
    if (free_avail !== 2'd3) begin n_fail++; $display("FAIL async_avail: got %0d want 3", free_avail); end
    n_checks++;
    if (free_pr !== {6'd32, 6'd33, 6'd34}) begin
      n_fail++;
      $display("FAIL async_pr: got %0d,%0d,%0d want 32,33,34", free_pr[2], free_pr[1], free_pr[0]);
    end
    alloc_req = 3'b000;
    #1;
    n_checks++;
    if (alloc_gnt !== 3'b000) begin n_fail++; $display("FAIL async_gnt: got %b want 000", alloc_gnt); end
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    @(posedge clock);
    #1;
  endtask

  task automatic test_wrap();
    logic [2:0] req, ret;
    int t[3];
    int n;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      req = 3'($urandom_range(3, 7));
      ret = 3'($urandom_range(0, 7));
      n = 0;
      for (int s = 2; s >= 0; s--) begin
        t[s] = 0;
        if (ret[s]) begin
          if (n < infl.size()) begin t[s] = infl[n]; n++; end
          else ret[s] = 1'b0;
        end
      end
      drive_cycle(req, ret, t[2], t[1], t[0], 1'b0);
    end
`ifdef FREELIST_DEBUG_EN
    n_checks++;
    if (head_disp !== 5'(alloc_total % DEPTH)) begin
      n_fail++; $display("FAIL head_disp: got %0d want %0d", head_disp, alloc_total % DEPTH);
    end
    n_checks++;
    if (tail_disp !== 5'(ret_total % DEPTH)) begin
      n_fail++; $display("FAIL tail_disp: got %0d want %0d", tail_disp, ret_total % DEPTH);
    end
`endif
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want completion before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alloc_all();
    test_alloc_sparse();
    test_exhaust();
    test_retire_from_empty();
    test_recovery();
    test_async_reset();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
